// File: rtl/family_iterator_if.sv
// family_iterator_if: request/result bundle between parent selection,
// the family iterator and fitness evaluation.
interface family_iterator_if #(
    parameter int GENE_BITS    = 5,
    parameter int GENE_COUNT   = 30,
    parameter int NUM_CHILDREN = 4
);
    localparam int W = GENE_BITS * GENE_COUNT;

    logic                            start;
    logic [31:0]                     prg_seed;
    logic [W-1:0]                    parent;
    logic [(NUM_CHILDREN+1)*W-1:0]   family;
    logic                            busy;
    logic                            done;

    modport master (
        output start,
        output prg_seed,
        output parent,
        input  family,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  prg_seed,
        input  parent,
        output family,
        output busy,
        output done
    );
endinterface

// File: rtl/family_iterator.sv
// family_iterator: builds a family from one parent chromosome -- the parent
// itself plus NUM_CHILDREN mutants, each mutated by SWAPS_PER_CHILD gene
// swaps whose indices come from a per-child Galois LFSR.
// Optional feature macro: FAMILY_ITER_DISTINCT_SWAP_EN (when defined, a swap
// whose two indices coincide is redirected to the neighbouring gene so every
// swap really moves two genes).
module family_iterator #(
    parameter int GENE_BITS       = 5,
    parameter int GENE_COUNT      = 30,
    parameter int NUM_CHILDREN    = 4,
    parameter int SWAPS_PER_CHILD = 1
) (
    input  logic            clk,
    input  logic            rst,
    family_iterator_if.slave bus
);
    localparam int W  = GENE_BITS * GENE_COUNT;
    localparam int CW = (SWAPS_PER_CHILD > 1) ? $clog2(SWAPS_PER_CHILD) : 1;

    localparam logic [CW-1:0] LAST_CNT  = CW'(SWAPS_PER_CHILD - 1);
    localparam logic [15:0]   GC16      = 16'(GENE_COUNT);
    localparam logic [15:0]   GC_LAST   = 16'(GENE_COUNT - 1);
    localparam logic [31:0]   LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0]   GOLDEN    = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // One Galois step: shift right, fold in the taps when the old LSB was set.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

    // Per-child seed; an all-zero LFSR would lock up, so it falls back to 1.
    function automatic logic [31:0] child_seed(input logic [31:0] seed,
                                               input logic [31:0] idx);
        logic [31:0] s;
        s = seed ^ (idx * GOLDEN);
        child_seed = (s == 32'h0000_0000) ? 32'h0000_0001 : s;
    endfunction

    // Map 16 random bits onto 0..GENE_COUNT-1 by fixed-point scaling.
    function automatic logic [15:0] scale_index(input logic [15:0] r);
        logic [31:0] p;
        p = {16'h0000, r} * {16'h0000, GC16};
        scale_index = p[31:16];
    endfunction

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;
    logic            done_r;
    logic [W-1:0]    slot0_r;
    logic [W-1:0]    child_r   [NUM_CHILDREN];
    logic [31:0]     lfsr_r    [NUM_CHILDREN];
    logic [W-1:0]    mutated_s [NUM_CHILDREN];

    for (genvar k = 0; k < NUM_CHILDREN; k++) begin : g_child
        logic [15:0]          idx_a_s;
        logic [15:0]          idx_b_raw_s;
        logic [15:0]          idx_b_s;
        logic [GENE_BITS-1:0] gene_a_s;
        logic [GENE_BITS-1:0] gene_b_s;
        logic [GENE_BITS-1:0] genes_s [GENE_COUNT];

        assign idx_a_s     = scale_index(lfsr_r[k][15:0]);
        assign idx_b_raw_s = scale_index(lfsr_r[k][31:16]);

`ifdef FAMILY_ITER_DISTINCT_SWAP_EN
        // Push a colliding second index to the next gene (wrapping to 0).
        always_comb begin
            idx_b_s = idx_b_raw_s;
            if (idx_b_raw_s == idx_a_s) begin
                if (idx_a_s == GC_LAST) begin
                    idx_b_s = 16'h0000;
                end else begin
                    idx_b_s = idx_a_s + 16'h0001;
                end
            end else begin
                idx_b_s = idx_b_raw_s;
            end
        end
`else
        assign idx_b_s = idx_b_raw_s;
`endif

        for (genvar g = 0; g < GENE_COUNT; g++) begin : g_unpack
            assign genes_s[g] = child_r[k][g*GENE_BITS +: GENE_BITS];
        end

        // Fetch the two genes that are about to trade places.
        always_comb begin
            gene_a_s = '0;
            gene_b_s = '0;
            for (int g = 0; g < GENE_COUNT; g++) begin
                gene_a_s = (idx_a_s == 16'(g)) ? genes_s[g] : gene_a_s;
                gene_b_s = (idx_b_s == 16'(g)) ? genes_s[g] : gene_b_s;
            end
        end

        for (genvar g = 0; g < GENE_COUNT; g++) begin : g_swap
            assign mutated_s[k][g*GENE_BITS +: GENE_BITS] =
                (idx_a_s == 16'(g)) ? gene_b_s :
                (idx_b_s == 16'(g)) ? gene_a_s : genes_s[g];
        end

        assign bus.family[(k+1)*W +: W] = child_r[k];
    end

    assign bus.family[0 +: W] = slot0_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;

    // Control FSM plus child/LFSR datapath; outputs are all registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            slot0_r <= '0;
            for (int k = 0; k < NUM_CHILDREN; k++) begin
                child_r[k] <= '0;
                lfsr_r[k]  <= 32'h0000_0001;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        slot0_r <= bus.parent;
                        for (int k = 0; k < NUM_CHILDREN; k++) begin
                            child_r[k] <= bus.parent;
                            lfsr_r[k]  <= child_seed(bus.prg_seed, 32'(k + 1));
                        end
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_MUTATE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUTATE: begin
                    for (int k = 0; k < NUM_CHILDREN; k++) begin
                        child_r[k] <= mutated_s[k];
                        lfsr_r[k]  <= lfsr_step(lfsr_r[k]);
                    end
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_CNT) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= ST_MUTATE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_family_iterator.sv
// Bench for family_iterator: a default instance (4 children, 1 swap) and a
// deep instance (8 children, 8 swaps), checked against a gene-array model.
module tb_family_iterator;
    localparam int GB = 5;
    localparam int GC = 30;
    localparam int W  = GB * GC;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   par_g [GC];
    int   exp_g [9][GC];

    family_iterator_if #(.GENE_BITS(GB), .GENE_COUNT(GC), .NUM_CHILDREN(4)) bus1 ();
    family_iterator_if #(.GENE_BITS(GB), .GENE_COUNT(GC), .NUM_CHILDREN(8)) bus8 ();

    family_iterator #(.GENE_BITS(GB), .GENE_COUNT(GC), .NUM_CHILDREN(4),
                      .SWAPS_PER_CHILD(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    family_iterator #(.GENE_BITS(GB), .GENE_COUNT(GC), .NUM_CHILDREN(8),
                      .SWAPS_PER_CHILD(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] parent_vec();
        logic [W-1:0] v;
        v = '0;
        for (int g = 0; g < GC; g++) v[g*GB +: GB] = GB'(par_g[g]);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_vec(input int s);
        logic [W-1:0] v;
        v = '0;
        for (int g = 0; g < GC; g++) v[g*GB +: GB] = GB'(exp_g[s][g]);
        return v;
    endfunction

    function automatic logic [W-1:0] slot1(input int s);
        return bus1.family[s*W +: W];
    endfunction

    function automatic logic [W-1:0] slot8(input int s);
        return bus8.family[s*W +: W];
    endfunction

    function automatic int diff_genes(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        for (int g = 0; g < GC; g++) if (x[g*GB +: GB] != y[g*GB +: GB]) n++;
        return n;
    endfunction

    function automatic bit same_multiset(input logic [W-1:0] x);
        int h [32];
        for (int i = 0; i < 32; i++) h[i] = 0;
        for (int g = 0; g < GC; g++) begin
            h[par_g[g]]++;
            h[int'(x[g*GB +: GB])]--;
        end
        for (int i = 0; i < 32; i++) if (h[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: start from the parent, apply sw random swaps per child.
    task automatic run_model(input logic [31:0] seed, input int nch, input int sw);
        logic [31:0] s;
        int a, b, t;
        for (int g = 0; g < GC; g++) exp_g[0][g] = par_g[g];
        for (int k = 0; k < nch; k++) begin
            s = seed ^ (32'(k + 1) * 32'h9E3779B9);
            if (s == 32'd0) s = 32'd1;
            for (int g = 0; g < GC; g++) exp_g[k+1][g] = par_g[g];
            for (int i = 0; i < sw; i++) begin
                a = int'((longint'(s) % 64'd65536) * GC / 65536);
                b = int'((longint'(s) / 64'd65536) * GC / 65536);
`ifdef FAMILY_ITER_DISTINCT_SWAP_EN
                if (a == b) b = (a == GC - 1) ? 0 : a + 1;
`endif
                t = exp_g[k+1][a];
                exp_g[k+1][a] = exp_g[k+1][b];
                exp_g[k+1][b] = t;
                s = (s % 2 == 1) ? ((s / 2) ^ 32'h80200003) : (s / 2);
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic run1(input logic [31:0] seed, output int lat);
        bus1.parent   = parent_vec();
        bus1.prg_seed = seed;
        bus1.start    = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        lat = 1;
        while (bus1.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input logic [31:0] seed, output int lat);
        bus8.parent   = parent_vec();
        bus8.prg_seed = seed;
        bus8.start    = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = 1;
        while (bus8.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int g = 0; g < GC; g++) par_g[g] = g;
        bus1.parent = parent_vec(); bus8.parent = parent_vec();
        bus1.prg_seed = $urandom; bus8.prg_seed = $urandom;
        bus1.start = 1'b1; bus8.start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks += 6;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", bus1.busy); end
        if (bus1.done !== 1'b0) begin errors++; $display("FAIL reset_done1: got %b expected 0", bus1.done); end
        if (bus1.family !== '0) begin errors++; $display("FAIL reset_family1: got %h expected 0", bus1.family); end
        if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b expected 0", bus8.busy); end
        if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done8: got %b expected 0", bus8.done); end
        if (bus8.family !== '0) begin errors++; $display("FAIL reset_family8: got %h expected 0", bus8.family); end
        bus1.start = 1'b0; bus8.start = 1'b0;
        rst = 1'b0;
        idle_cycle();
        checks++;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus1.busy); end
    endtask

    task automatic test_single_run();
        int lat, d;
        for (int g = 0; g < GC; g++) par_g[g] = g;
        run_model(32'h12345678, 4, 1);
        run1(32'h12345678, lat);
        checks += 2;
        if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", lat); end
        if (bus1.busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_done: got %b expected 1", bus1.busy); end
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (slot1(s) !== exp_vec(s)) begin
                errors++; $display("FAIL single_slot%0d: got %h expected %h", s, slot1(s), exp_vec(s));
            end
        end
        for (int s = 1; s < 5; s++) begin
            d = diff_genes(slot1(s), parent_vec());
            checks++;
            if (!(d == 0 || d == 2)) begin
                errors++; $display("FAIL single_diff%0d: got %0d genes changed expected 0 or 2", s, d);
            end
        end
        idle_cycle();
        checks += 3;
        if (bus1.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", bus1.done); end
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b expected 0", bus1.busy); end
        if (slot1(1) !== exp_vec(1)) begin errors++; $display("FAIL family_hold: got %h expected %h", slot1(1), exp_vec(1)); end
    endtask

    task automatic test_seed_fallback();
        int lat;
        logic [W-1:0] c0;
        for (int g = 0; g < GC; g++) par_g[g] = g;
        c0 = parent_vec();
`ifdef FAMILY_ITER_DISTINCT_SWAP_EN
        c0[4:0] = 5'd1;
        c0[9:5] = 5'd0;
`endif
        run_model(32'h9E3779B9, 4, 1);
        run1(32'h9E3779B9, lat);
        checks += 2;
        if (lat !== 2) begin errors++; $display("FAIL fallback_latency: got %0d expected 2", lat); end
        if (slot1(1) !== c0) begin errors++; $display("FAIL fallback_child0: got %h expected %h", slot1(1), c0); end
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (slot1(s) !== exp_vec(s)) begin
                errors++; $display("FAIL fallback_slot%0d: got %h expected %h", s, slot1(s), exp_vec(s));
            end
        end
        idle_cycle();
    endtask

    task automatic test_handshake();
        logic [31:0] seed;
        int ndone, c;
        int pos [$];
        bit bad;
        // A second start during MUTATE must be ignored.
        for (int g = 0; g < GC; g++) par_g[g] = g;
        seed = $urandom;
        run_model(seed, 8, 8);
        bus8.parent = parent_vec(); bus8.prg_seed = seed; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        ndone = 0;
        repeat (2) begin @(posedge clk); #1; if (bus8.done === 1'b1) ndone++; end
        bus8.prg_seed = ~seed; bus8.parent = '0; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        if (bus8.done === 1'b1) ndone++;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1) begin
                ndone++;
                for (int s = 0; s < 9; s++) begin
                    checks++;
                    if (slot8(s) !== exp_vec(s)) begin
                        errors++; $display("FAIL ignore_start_slot%0d: got %h expected %h", s, slot8(s), exp_vec(s));
                    end
                end
            end
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL ignore_start_dones: got %0d expected 1", ndone); end

        // Held start: back-to-back runs, done every 3 cycles.
        seed = $urandom;
        run_model(seed, 4, 1);
        bus1.parent = parent_vec(); bus1.prg_seed = seed; bus1.start = 1'b1;
        for (c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (bus1.done === 1'b1) begin
                pos.push_back(c);
                bad = 1'b0;
                for (int s = 0; s < 5; s++) if (slot1(s) !== exp_vec(s)) bad = 1'b1;
                checks++;
                if (bad) begin errors++; $display("FAIL b2b_family: got %h expected slot1 %h", bus1.family, exp_vec(1)); end
            end
        end
        bus1.start = 1'b0;
        checks += 2;
        if (pos.size() < 5) begin errors++; $display("FAIL b2b_count: got %0d expected at least 5", pos.size()); end
        if (pos.size() > 0 && pos[0] != 1) begin errors++; $display("FAIL b2b_first: got %0d expected 1", pos[0]); end
        for (int i = 1; i < pos.size(); i++) begin
            checks++;
            if (pos[i] - pos[i-1] != 3) begin
                errors++; $display("FAIL b2b_period: got %0d expected 3", pos[i] - pos[i-1]);
            end
        end
        repeat (4) idle_cycle();
    endtask

    task automatic test_reset_midrun();
        logic [31:0] seed;
        int ndone, lat;
        for (int g = 0; g < GC; g++) par_g[g] = $urandom_range(0, 31);
        bus8.parent = parent_vec(); bus8.prg_seed = $urandom; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks += 3;
        if (bus8.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus8.busy); end
        if (bus8.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus8.done); end
        if (bus8.family !== '0) begin errors++; $display("FAIL midrst_family: got %h expected 0", bus8.family); end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin @(posedge clk); #1; if (bus8.done === 1'b1) ndone++; end
        checks += 2;
        if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
        if (bus8.busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b expected 0", bus8.busy); end
        seed = $urandom;
        run_model(seed, 8, 8);
        run8(seed, lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL midrst_rerun_latency: got %0d expected 9", lat); end
        for (int s = 0; s < 9; s++) begin
            checks++;
            if (slot8(s) !== exp_vec(s)) begin
                errors++; $display("FAIL midrst_rerun_slot%0d: got %h expected %h", s, slot8(s), exp_vec(s));
            end
        end
        idle_cycle();
    endtask

    task automatic test_depth();
        logic [31:0] seed;
        int lat;
        for (int it = 0; it < 100; it++) begin
            for (int g = 0; g < GC; g++) par_g[g] = $urandom_range(0, 31);
            seed = $urandom;
            run_model(seed, 8, 8);
            run8(seed, lat);
            checks++;
            if (lat !== 9) begin errors++; $display("FAIL depth_latency it%0d: got %0d expected 9", it, lat); end
            for (int s = 0; s < 9; s++) begin
                checks++;
                if (slot8(s) !== exp_vec(s)) begin
                    errors++; $display("FAIL depth_slot%0d it%0d: got %h expected %h", s, it, slot8(s), exp_vec(s));
                end
            end
            for (int s = 1; s < 9; s++) begin
                checks++;
                if (!same_multiset(slot8(s))) begin
                    errors++; $display("FAIL depth_multiset%0d it%0d: got %h parent %h", s, it, slot8(s), parent_vec());
                end
            end
            idle_cycle();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus1.start = 1'b0; bus8.start = 1'b0;
        bus1.prg_seed = '0; bus8.prg_seed = '0;
        bus1.parent = '0; bus8.parent = '0;
        test_reset();
        test_single_run();
        test_seed_fallback();
        test_handshake();
        test_reset_midrun();
        test_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
